fsm_pattern_tx: RTL and testbench
=================================

# fsm_pattern_tx

Serial pattern transmitter, the driving end of the sequence-detector path. It loads a bit pattern of programmable length and shifts it out one bit per `tick` strobe from `clk_divider`. Each frame is followed by a guard gap, and the pattern can repeat continuously. The serial output feeds the detector's `enable` input. A BCD frame counter drives a `decoder_0_F` instance for HEX display.

## Interface
- `PATTERN_W`, default 8: pattern register width (bits), 2..15.
- `GAP_TICKS`, default 2: extra zero-bit periods after the mandatory one following each frame; 0 allowed.

- `clk`  in  1: system clock. One clock; reset is synchronous and active-high.
- `rst_a_p`  in  1: synchronous active-high reset, sampled on `clk` rising edge.
- `tick`  in  1: one-`clk`-wide bit-period strobe; all serial activity advances only on cycles with `tick`=1.
- `start`  in  1: frame request, sampled only in IDLE.
- `loop`  in  1: repeat the captured pattern after each gap while high.
- `pattern_in`  in  PATTERN_W: bits to send; bits `[len-1:0]` are used.
- `len_in`  in  4: frame length; 0 or >PATTERN_W is treated as PATTERN_W.
- `serial_out`  out  1: transmitted bit, MSB-first (`pattern[len-1]` first).
- `bit_valid`  out  1: high while `serial_out` carries a pattern bit.
- `busy`  out  1: high from the start-accept cycle until return to IDLE.
- `done`  out  1: one-`clk` pulse per completed frame.
- `frame_cnt`  out  4: completed frames, BCD 0..9, wraps 9→0.

## Operation
- States: IDLE, SEND, GAP.
- IDLE: `serial_out`=0, `bit_valid`=0, `busy`=0. On `start`=1, capture `pattern_in` and effective length (clamped). Load the shift register left-justified and set `remaining` = len. Go to SEND. A `tick` in the accept cycle is ignored.
- SEND, `tick` with `remaining`>0: `serial_out` ← shift MSB, shift left, `remaining`−1, `bit_valid`=1.
- SEND, `tick` with `remaining`=0:
  - `serial_out`=0, `bit_valid`=0, `done` pulses this cycle, `frame_cnt` increments (BCD wrap).
  - If `GAP_TICKS`=0, go to end-of-gap handling directly. Otherwise go to GAP with `gap_cnt`=GAP_TICKS.
- GAP, each `tick`: `gap_cnt`−1. When it reaches 0, go to end-of-gap handling.
- End of gap:
  - `loop`=1: reload the captured pattern (not `pattern_in`), set `remaining`=len, go to SEND.
  - `loop`=0: go to IDLE.
- `loop` is sampled only at end of gap. Deasserting it mid-frame finishes the current frame and gap.
- `start` while `busy` is ignored. `pattern_in` and `len_in` changes while busy have no effect.
- Every frame emits exactly len pattern bits followed by 1+GAP_TICKS zero periods.

## Timing
- Reset (synchronous): the cycle after `rst_a_p`=1, the block is in IDLE and all outputs are 0, including `frame_cnt`=0 and `done`=0. This holds even mid-frame or mid-gap.
- Reset has priority over `start` and `tick` in the same cycle.
- `serial_out` and `bit_valid` are registered and change only in the cycle after a `tick` edge. They hold stable for the whole bit period.
- Latency: with `start` accepted at cycle N, the first bit appears after the first `tick` at cycle ≥N+1.
- `done` and the `frame_cnt` update occur in the same cycle as the `serial_out`→0 transition.
- `busy` falls in the cycle after the final gap tick when `loop`=0. A `start` at that same cycle boundary is accepted on the next IDLE cycle.
- Consecutive `tick` cycles (divider bypassed) are legal: one bit per `clk`.

## Test plan
- PATTERN_W=8, `pattern_in`=8'h0B, `len_in`=4, `start` pulse, `tick` every 4 clks. Required: `serial_out` = 1,0,1,1 with `bit_valid` high for exactly 4 tick periods. Then 3 zero periods, one `done` pulse, `frame_cnt`=1, `busy` low.
- `len_in`=0 and `len_in`=12 with `pattern_in`=8'hA5. Required in both cases: 8 bits sent, 1,0,1,0,0,1,0,1.
- `loop`=1, `pattern_in`=8'h0B, `len_in`=4, 12 frames. Required: the 1011 + 000 stream repeats, `frame_cnt` counts 1..9,0,1,2. Change `pattern_in` mid-run: no effect. Drop `loop` mid-frame: the frame and gap complete, then IDLE.
- `rst_a_p` asserted during the third bit. Required: the next cycle shows `serial_out`=0, `bit_valid`=0, `busy`=0, `frame_cnt`=0. No `done` pulse.
- `start` and `tick` in the same IDLE cycle. Required: no bit output on that tick; the first bit follows the next tick. A `start` during SEND is ignored.
- `tick` held high continuously, GAP_TICKS=0, `len_in`=3. Required: 3 bits on consecutive clks, then one zero clk and `done`.

Source files
------------

// File: rtl/fsm_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, one bit per tick,
// followed by a zero guard gap, optionally repeating while loop is high.
module fsm_pattern_tx #(
    parameter int unsigned PATTERN_W = 8,
    parameter int unsigned GAP_TICKS = 2
) (
    input  logic                 clk,
    input  logic                 rst_a_p,
    input  logic                 tick,
    input  logic                 start,
    input  logic                 loop,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic [3:0]           len_in,
    output logic                 serial_out,
    output logic                 bit_valid,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           frame_cnt
);

    localparam int unsigned GapW   = (GAP_TICKS < 1) ? 1 : $clog2(GAP_TICKS + 1);
    localparam logic [3:0]  PatLen = 4'(PATTERN_W);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e                 state_q, state_d;
    logic [PATTERN_W-1:0]   pat_q, pat_d;
    logic [PATTERN_W-1:0]   sr_q, sr_d;
    logic [3:0]             len_q, len_d;
    logic [3:0]             rem_q, rem_d;
    logic [GapW-1:0]        gap_q, gap_d;
    logic                   ser_q, ser_d;
    logic                   bv_q, bv_d;
    logic                   done_q, done_d;
    logic [3:0]             fcnt_q, fcnt_d;
    logic [3:0]             eff_len;
    logic                   end_of_gap;

    // Lengths of zero or wider than the register fall back to the full width.
    assign eff_len = ((len_in == 4'd0) || (len_in > PatLen)) ? PatLen : len_in;

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        sr_d       = sr_q;
        len_d      = len_q;
        rem_d      = rem_q;
        gap_d      = gap_q;
        ser_d      = ser_q;
        bv_d       = bv_q;
        done_d     = 1'b0;
        fcnt_d     = fcnt_q;
        end_of_gap = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pat_d   = pattern_in;
                    len_d   = eff_len;
                    sr_d    = pattern_in << (PatLen - eff_len);
                    rem_d   = eff_len;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (tick) begin
                    if (rem_q != 4'd0) begin
                        ser_d = sr_q[PATTERN_W-1];
                        sr_d  = {sr_q[PATTERN_W-2:0], 1'b0};
                        rem_d = rem_q - 4'd1;
                        bv_d  = 1'b1;
                    end else begin
                        ser_d  = 1'b0;
                        bv_d   = 1'b0;
                        done_d = 1'b1;
                        fcnt_d = (fcnt_q == 4'd9) ? 4'd0 : fcnt_q + 4'd1;
                        if (GAP_TICKS == 0) begin
                            end_of_gap = 1'b1;
                        end else begin
                            gap_d   = GapW'(GAP_TICKS);
                            state_d = StGap;
                        end
                    end
                end
            end
            StGap: begin
                if (tick) begin
                    gap_d = gap_q - GapW'(1);
                    if (gap_q == GapW'(1)) begin
                        end_of_gap = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Repeats always use the captured pattern, never the live input.
        if (end_of_gap) begin
            if (loop) begin
                sr_d    = pat_q << (PatLen - len_q);
                rem_d   = len_q;
                state_d = StSend;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            state_q <= StIdle;
            pat_q   <= '0;
            sr_q    <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            gap_q   <= '0;
            ser_q   <= 1'b0;
            bv_q    <= 1'b0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sr_q    <= sr_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            ser_q   <= ser_d;
            bv_q    <= bv_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign serial_out = ser_q;
    assign bit_valid  = bv_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_fsm_pattern_tx.sv
// Self-checking bench for fsm_pattern_tx: table-driven frames checked through a scoreboard,
// plus hand-written sequences for reset, looping and back-to-back ticks.
module tb_fsm_pattern_tx;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst_a_p, tick, start, loop;
    logic [7:0] pattern_in;
    logic [3:0] len_in;
    logic       serial_out, bit_valid, busy, done;
    logic [3:0] frame_cnt;

    logic       tick0, start0, loop0;
    logic [7:0] pattern0;
    logic [3:0] len0;
    logic       ser0, bv0, busy0, done0;
    logic [3:0] fcnt0;

    fsm_pattern_tx #(.PATTERN_W(8), .GAP_TICKS(GAP)) dut (
        .clk(clk), .rst_a_p(rst_a_p), .tick(tick), .start(start), .loop(loop),
        .pattern_in(pattern_in), .len_in(len_in), .serial_out(serial_out),
        .bit_valid(bit_valid), .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    fsm_pattern_tx #(.PATTERN_W(8), .GAP_TICKS(0)) dut0 (
        .clk(clk), .rst_a_p(rst_a_p), .tick(tick0), .start(start0), .loop(loop0),
        .pattern_in(pattern0), .len_in(len0), .serial_out(ser0),
        .bit_valid(bv0), .busy(busy0), .done(done0), .frame_cnt(fcnt0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ser;
        logic       bv;
        logic       dn;
        logic [3:0] fc;
        logic       bsy;
    } exp_t;

    typedef struct {
        logic [7:0] pat;
        logic [3:0] len;
        logic [7:0] bits;
        int         n;
    } vec_t;

    exp_t     sb[$];
    vec_t     vecs[7];
    int       n_checks = 0;
    int       n_fail   = 0;
    logic [3:0] fcnt_m = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-tick outputs for one frame: bits, done tick, then the gap ticks.
    task automatic push_frame(input logic [7:0] bits, input int n, input logic last);
        exp_t e;
        for (int i = n - 1; i >= 0; i--) begin
            e = '{ser: bits[i], bv: 1'b1, dn: 1'b0, fc: fcnt_m, bsy: 1'b1};
            sb.push_back(e);
        end
        fcnt_m = (fcnt_m == 4'd9) ? 4'd0 : fcnt_m + 4'd1;
        e = '{ser: 1'b0, bv: 1'b0, dn: 1'b1, fc: fcnt_m, bsy: 1'b1};
        sb.push_back(e);
        for (int g = 1; g <= GAP; g++) begin
            e = '{ser: 1'b0, bv: 1'b0, dn: 1'b0, fc: fcnt_m, bsy: (g == GAP) ? !last : 1'b1};
            sb.push_back(e);
        end
    endtask

    task automatic tick_check();
        exp_t e;
        @(negedge clk) tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        if (sb.size() == 0) begin
            chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("serial_out", serial_out, e.ser);
            chk("bit_valid", bit_valid, e.bv);
            chk("done", done, e.dn);
            chk("frame_cnt", frame_cnt, e.fc);
            chk("busy", busy, e.bsy);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic do_start(input logic [7:0] p, input logic [3:0] l);
        @(negedge clk);
        pattern_in = p;
        len_in     = l;
        start      = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{pat: 8'h0B, len: 4'd4,  bits: 8'h0B, n: 4};
        vecs[1] = '{pat: 8'hA5, len: 4'd0,  bits: 8'hA5, n: 8};
        vecs[2] = '{pat: 8'hA5, len: 4'd12, bits: 8'hA5, n: 8};
        vecs[3] = '{pat: 8'h3C, len: 4'd8,  bits: 8'h3C, n: 8};
        vecs[4] = '{pat: 8'hFF, len: 4'd1,  bits: 8'h01, n: 1};
        vecs[5] = '{pat: 8'h96, len: 4'd7,  bits: 8'h16, n: 7};
        vecs[6] = '{pat: 8'hC3, len: 4'd2,  bits: 8'h03, n: 2};

        rst_a_p = 1'b1; tick = 1'b0; start = 1'b0; loop = 1'b0;
        pattern_in = '0; len_in = '0;
        tick0 = 1'b0; start0 = 1'b0; loop0 = 1'b0; pattern0 = '0; len0 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_serial_out", serial_out, 1'b0);
        chk("rst_bit_valid", bit_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 4'd0);
        @(negedge clk) rst_a_p = 1'b0;

        // Single frames from the vector table.
        foreach (vecs[v]) begin
            do_start(vecs[v].pat, vecs[v].len);
            push_frame(vecs[v].bits, vecs[v].n, 1'b1);
            while (sb.size() != 0) tick_check();
            chk("idle_after_frame", busy, 1'b0);
        end

        // start coincident with tick in IDLE: that tick must not shift a bit.
        @(negedge clk);
        pattern_in = 8'h0B; len_in = 4'd4; start = 1'b1; tick = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; tick = 1'b0;
        chk("start_tick_ser", serial_out, 1'b0);
        chk("start_tick_bv", bit_valid, 1'b0);
        chk("start_tick_busy", busy, 1'b1);
        push_frame(8'h0B, 4, 1'b1);
        tick_check();
        tick_check();
        // A start during SEND with new data must be ignored.
        @(negedge clk);
        pattern_in = 8'hFF; len_in = 4'd8; start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (sb.size() != 0) tick_check();
        chk("idle_after_ignored_start", busy, 1'b0);

        // Reset during the third bit of a frame.
        do_start(8'h0B, 4'd4);
        push_frame(8'h0B, 4, 1'b1);
        repeat (3) tick_check();
        sb.delete();
        @(negedge clk) rst_a_p = 1'b1; tick = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_serial_out", serial_out, 1'b0);
        chk("midrst_bit_valid", bit_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_frame_cnt", frame_cnt, 4'd0);
        chk("midrst_done", done, 1'b0);
        @(negedge clk) rst_a_p = 1'b0; tick = 1'b0;
        fcnt_m = 4'd0;
        repeat (2) @(posedge clk);
        #1 chk("midrst_still_idle", busy, 1'b0);

        // Looping: 12 frames, pattern_in changed mid-run, loop dropped inside frame 12.
        loop = 1'b1;
        do_start(8'h0B, 4'd4);
        for (int f = 0; f < 12; f++) begin
            push_frame(8'h0B, 4, f == 11);
            for (int t = 0; t < 4 + 1 + GAP; t++) begin
                if (f == 3 && t == 0) begin
                    pattern_in = 8'hFF;
                    len_in     = 4'd8;
                end
                if (f == 11 && t == 2) loop = 1'b0;
                tick_check();
            end
        end
        chk("loop_final_cnt", frame_cnt, 4'd2);
        chk("loop_final_busy", busy, 1'b0);

        // Second instance with no gap and tick held high: one bit per clk.
        @(negedge clk);
        pattern0 = 8'h06; len0 = 4'd3; start0 = 1'b1; tick0 = 1'b1;
        @(posedge clk);
        #1;
        chk("cont_accept_bv", bv0, 1'b0);
        chk("cont_accept_busy", busy0, 1'b1);
        @(negedge clk) start0 = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            @(posedge clk);
            #1;
            chk("cont_bit", ser0, pattern0[i]);
            chk("cont_bv", bv0, 1'b1);
            chk("cont_done_low", done0, 1'b0);
        end
        @(posedge clk);
        #1;
        chk("cont_zero_ser", ser0, 1'b0);
        chk("cont_zero_bv", bv0, 1'b0);
        chk("cont_done", done0, 1'b1);
        chk("cont_fcnt", fcnt0, 4'd1);
        @(posedge clk);
        #1;
        chk("cont_idle_busy", busy0, 1'b0);
        chk("cont_done_pulse_end", done0, 1'b0);
        @(negedge clk) tick0 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
